// File: rtl/control_pkg.sv
// ============================================================================
// control_pkg : shared state, opcode, ALU-function, bus-source and branch
//               condition encodings for control_fsm.      Rev 1.0
// ============================================================================
`default_nettype none

package control_pkg;

  typedef enum logic [2:0] {
    S_FETCH     = 3'd0,
    S_DECODE    = 3'd1,
    S_EXECUTE   = 3'd2,
    S_WRITEBACK = 3'd3,
    S_HALT      = 3'd4
  } state_t;

  localparam logic [2:0] OP_NOP = 3'b000;
  localparam logic [2:0] OP_MOV = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_SUB = 3'b011;
  localparam logic [2:0] OP_AND = 3'b100;
  localparam logic [2:0] OP_LDI = 3'b101;
  localparam logic [2:0] OP_JMP = 3'b110;
  localparam logic [2:0] OP_SYS = 3'b111;

  localparam logic [2:0] FUN_PASS = 3'b000;
  localparam logic [2:0] FUN_ADD  = 3'b001;
  localparam logic [2:0] FUN_SUB  = 3'b010;
  localparam logic [2:0] FUN_AND  = 3'b011;

  localparam logic [1:0] OB_IDLE = 2'b00;
  localparam logic [1:0] OB_REG  = 2'b01;
  localparam logic [1:0] OB_ALU  = 2'b10;
  localparam logic [1:0] OB_IMM  = 2'b11;

  localparam logic [31:0] CC_ALWAYS = 32'd0;
  localparam logic [31:0] CC_Z      = 32'd1;
  localparam logic [31:0] CC_C      = 32'd2;
  localparam logic [31:0] CC_N      = 32'd3;
  localparam logic [31:0] CC_NZ     = 32'd4;

  localparam logic [31:0] SYS_HALT = 32'd0;
  localparam logic [31:0] SYS_CALL = 32'd1;
  localparam logic [31:0] SYS_RET  = 32'd2;

  // flags are packed {N, C, Z}
  function automatic logic cond_taken(input logic [31:0] cc, input logic [2:0] flags);
    logic w_taken;
    w_taken = 1'b0;
    case (cc)
      CC_ALWAYS: w_taken = 1'b1;
      CC_Z:      w_taken = flags[0];
      CC_C:      w_taken = flags[1];
      CC_N:      w_taken = flags[2];
      CC_NZ:     w_taken = ~flags[0];
      default:   w_taken = 1'b0;
    endcase
    return w_taken;
  endfunction

endpackage

`default_nettype wire

// File: rtl/ret_stack.sv
// ============================================================================
// ret_stack : DEPTH x WIDTH LIFO of return addresses with full/empty flags.
//             Rev 1.0
// ============================================================================
`default_nettype none

module ret_stack
  import control_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_push,
  input  logic             i_pop,
  input  logic [WIDTH-1:0] i_data,
  output logic [WIDTH-1:0] o_data,
  output logic             o_full,
  output logic             o_empty
);

  localparam int SP_W  = $clog2(DEPTH + 1);
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [SP_W-1:0]  r_sp;
  logic [IDX_W-1:0] w_wr_idx;
  logic [IDX_W-1:0] w_rd_idx;

  assign w_wr_idx = IDX_W'(r_sp);
  assign w_rd_idx = IDX_W'(r_sp - SP_W'(1));
  assign o_full   = (r_sp == SP_W'(DEPTH));
  assign o_empty  = (r_sp == '0);
  assign o_data   = r_mem[w_rd_idx];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sp <= '0;
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else if (i_push && !o_full) begin
      r_mem[w_wr_idx] <= i_data;
      r_sp            <= r_sp + SP_W'(1);
    end else if (i_pop && !o_empty) begin
      r_sp <= r_sp - SP_W'(1);
    end
  end

endmodule

`default_nettype wire

// File: rtl/control_fsm.sv
// ============================================================================
// control_fsm : fetch/decode/execute/writeback sequencer for a small register
//               machine. Optional CALL/RET return stack: CALL_STACK_EN. Rev 1.0
// ============================================================================
`default_nettype none

module control_fsm
  import control_pkg::*;
#(
  parameter int ADDR_W      = 8,
  parameter int DATA_W      = 8,
  parameter int NREG        = 8,
  parameter int STACK_DEPTH = 4
) (
  input  logic                           Clk,
  input  logic                           Rst,
  input  logic [3+2*$clog2(NREG)-1:0]    ms_m,
  input  logic [DATA_W-1:0]              DataOut_Bus,
  input  logic [2:0]                     band,
  input  logic                           Stall,
  output logic [2:0]                     fun,
  output logic [NREG-1:0]                b_sel,
  output logic [$clog2(NREG)-1:0]        c_sel,
  output logic                           LE_sel,
  output logic [1:0]                     outbus,
  output logic [ADDR_W-1:0]              Address_Instruction_Bus,
  output logic                           Halted,
  output logic                           Err
);

  localparam int REG_W   = $clog2(NREG);
  localparam int INSTR_W = 3 + 2 * REG_W;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [ADDR_W-1:0]  r_pc;
  logic [INSTR_W-1:0] r_ir;
  logic [2:0]         r_flags;

  logic [2:0]         w_op;
  logic [REG_W-1:0]   w_dst;
  logic [REG_W-1:0]   w_src;
  logic [31:0]        w_dst32;
  logic [31:0]        w_src32;
  logic [NREG-1:0]    w_onehot;
  logic [2:0]         w_fun;
  logic [1:0]         w_ob;
  logic               w_rd;
  logic               w_is_wr;
  logic               w_is_alu;
  logic               w_is_halt;
  logic [ADDR_W-1:0]  w_pc_inc;
  logic [ADDR_W-1:0]  w_pc_nxt;
  logic [ADDR_W-1:0]  w_target;
  logic [ADDR_W-1:0]  w_stk_top;
  logic               w_call_ok;
  logic               w_ret_ok;
  logic               w_unused;

  assign w_op      = r_ir[INSTR_W-1 -: 3];
  assign w_dst     = r_ir[2*REG_W-1 -: REG_W];
  assign w_src     = r_ir[REG_W-1:0];
  assign w_dst32   = 32'(w_dst);
  assign w_src32   = 32'(w_src);
  assign w_onehot  = NREG'(1) << w_src;
  assign w_pc_inc  = r_pc + ADDR_W'(1);
  assign w_target  = DataOut_Bus[ADDR_W-1:0];
  assign w_unused  = ^DataOut_Bus;
  assign w_is_wr   = (w_ob != OB_IDLE);
  assign w_is_alu  = (w_op == OP_ADD) || (w_op == OP_SUB) || (w_op == OP_AND);
  assign w_is_halt = (w_op == OP_SYS) && (w_src32 == SYS_HALT);

  assign Address_Instruction_Bus = r_pc;
  assign Halted                  = (r_state == S_HALT);

`ifdef CALL_STACK_EN
  logic w_is_call;
  logic w_is_ret;
  logic w_full;
  logic w_empty;
  logic w_push;
  logic w_pop;
  logic r_err;

  assign w_is_call = (w_op == OP_SYS) && (w_src32 == SYS_CALL);
  assign w_is_ret  = (w_op == OP_SYS) && (w_src32 == SYS_RET);
  assign w_call_ok = w_is_call && !w_full;
  assign w_ret_ok  = w_is_ret && !w_empty;
  assign w_push    = (r_state == S_WRITEBACK) && w_call_ok;
  assign w_pop     = (r_state == S_WRITEBACK) && w_ret_ok;

  ret_stack #(
    .DEPTH (STACK_DEPTH),
    .WIDTH (ADDR_W)
  ) u_ret_stack (
    .clk     (Clk),
    .rst_n   (Rst),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_data  (w_pc_inc),
    .o_data  (w_stk_top),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  // A rejected CALL/RET still retires as a NOP; only the fault is remembered.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      r_err <= 1'b0;
    end else if ((r_state == S_WRITEBACK) &&
                 ((w_is_call && w_full) || (w_is_ret && w_empty))) begin
      r_err <= 1'b1;
    end
  end

  assign Err = r_err;
`else
  assign w_call_ok = 1'b0;
  assign w_ret_ok  = 1'b0;
  assign w_stk_top = '0;
  assign Err       = 1'b0;
`endif

  always_comb begin
    w_fun = FUN_PASS;
    w_ob  = OB_IDLE;
    w_rd  = 1'b0;
    case (w_op)
      OP_MOV: begin w_ob = OB_REG; w_rd = 1'b1; end
      OP_ADD: begin w_ob = OB_ALU; w_rd = 1'b1; w_fun = FUN_ADD; end
      OP_SUB: begin w_ob = OB_ALU; w_rd = 1'b1; w_fun = FUN_SUB; end
      OP_AND: begin w_ob = OB_ALU; w_rd = 1'b1; w_fun = FUN_AND; end
      OP_LDI: begin w_ob = OB_IMM; end
      default: ;
    endcase
  end

  always_comb begin
    w_pc_nxt = w_pc_inc;
    case (w_op)
      OP_JMP: if (cond_taken(w_dst32, r_flags)) w_pc_nxt = w_target;
      OP_SYS: begin
        if (w_is_halt)      w_pc_nxt = r_pc;
        else if (w_call_ok) w_pc_nxt = w_target;
        else if (w_ret_ok)  w_pc_nxt = w_stk_top;
      end
      default: ;
    endcase
  end

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      r_state <= S_FETCH;
      r_pc    <= '0;
      r_ir    <= '0;
      r_flags <= '0;
    end else begin
      r_state <= w_state_nxt;
      if ((r_state == S_FETCH) && !Stall)     r_ir    <= ms_m;
      if ((r_state == S_EXECUTE) && w_is_alu) r_flags <= band;
      if (r_state == S_WRITEBACK)             r_pc    <= w_pc_nxt;
    end
  end

  // Datapath controls are held through WRITEBACK so the written value is stable.
  always_comb begin
    w_state_nxt = r_state;
    fun         = FUN_PASS;
    b_sel       = '0;
    c_sel       = '0;
    LE_sel      = 1'b0;
    outbus      = OB_IDLE;
    case (r_state)
      S_FETCH:  if (!Stall) w_state_nxt = S_DECODE;
      S_DECODE: w_state_nxt = S_EXECUTE;
      S_EXECUTE: begin
        w_state_nxt = S_WRITEBACK;
        if (w_is_wr) begin
          fun    = w_fun;
          outbus = w_ob;
          b_sel  = w_rd ? w_onehot : '0;
        end
      end
      S_WRITEBACK: begin
        w_state_nxt = w_is_halt ? S_HALT : S_FETCH;
        if (w_is_wr) begin
          fun    = w_fun;
          outbus = w_ob;
          b_sel  = w_rd ? w_onehot : '0;
          c_sel  = w_dst;
          LE_sel = 1'b1;
        end
      end
      S_HALT:  w_state_nxt = S_HALT;
      default: w_state_nxt = S_FETCH;
    endcase
  end

endmodule

`default_nettype wire

// File: doc/control_fsm.md
CONTROL_FSM -- requirements
Module: control_fsm

Interface
REQ-001 Parameter ADDR_W, default 8, width of the program counter and Address_Instruction_Bus.
REQ-002 Parameter DATA_W, default 8, width of DataOut_Bus.
REQ-003 Parameter NREG, default 8, register count (power of 2); REG_W = clog2(NREG); instruction width INSTR_W = 3 + 2*REG_W.
REQ-004 Parameter STACK_DEPTH, default 4, return-stack entries (used only with CALL_STACK_EN).
REQ-005 Clk  in  1  single clock, rising edge.
REQ-006 Rst  in  1  reset, asynchronous, active-low.
REQ-007 ms_m  in  INSTR_W  instruction word {op[2:0], dst[REG_W-1:0], src[REG_W-1:0]}.
REQ-008 DataOut_Bus  in  DATA_W  immediate or jump target; low ADDR_W bits used as target.
REQ-009 band  in  3  ALU flags {N, C, Z}.
REQ-010 Stall  in  1  holds the FSM in FETCH while high.
REQ-011 fun  out  3  ALU function: 000 pass, 001 add, 010 sub, 011 and.
REQ-012 b_sel  out  NREG  one-hot register read select.
REQ-013 c_sel  out  REG_W  register write address.
REQ-014 LE_sel  out  1  register write enable.
REQ-015 outbus  out  2  bus source: 00 idle, 01 register, 10 ALU, 11 immediate.
REQ-016 Address_Instruction_Bus  out  ADDR_W  program counter.
REQ-017 Halted  out  1  high in HALT.
REQ-018 Err  out  1  sticky stack fault flag.

Function
REQ-019 States FETCH, DECODE, EXECUTE, WRITEBACK, HALT; non-halting instruction takes exactly 4 cycles with Stall low.
REQ-020 FETCH: Address_Instruction_Bus = PC; ms_m captured into IR on the edge leaving FETCH; Stall=1 keeps FETCH and IR unchanged.
REQ-021 Opcodes: 000 NOP, 001 MOV dst<-src, 010 ADD, 011 SUB, 100 AND (dst<-dst op src), 101 LDI dst<-DataOut_Bus, 110 JMP, 111 SYS.
REQ-022 EXECUTE: b_sel = onehot(src), outbus = 01 for MOV, 10 for ADD/SUB/AND, 11 for LDI; fun per REQ-011.
REQ-023 band sampled into a flag register at the end of EXECUTE for ADD/SUB/AND only; other ops leave flags unchanged.
REQ-024 WRITEBACK: LE_sel=1 for exactly one cycle with c_sel = dst and outbus held from EXECUTE, for MOV/ADD/SUB/AND/LDI only.
REQ-025 JMP: dst field is the condition: 0 always, 1 Z, 2 C, 3 N, 4 not Z, others never; taken -> PC = DataOut_Bus[ADDR_W-1:0] at end of WRITEBACK, else PC+1.
REQ-026 PC increments modulo 2^ADDR_W; 2^ADDR_W-1 wraps to 0.
REQ-027 SYS with src=0: HALT; PC frozen; Halted=1; leaves HALT only via reset.
REQ-028 SYS with src other than 0, 1 or 2: NOP.
REQ-029 Outside EXECUTE/WRITEBACK: fun=000, b_sel=0, outbus=00, LE_sel=0.

Reset
REQ-030 Rst low: immediately state=FETCH, PC=0, IR=0, flags=0, stack pointer=0, Err=0, all outputs at REQ-029 values, Halted=0.
REQ-031 Reset asserted mid-instruction aborts it; no LE_sel pulse is produced.
REQ-032 After release, first FETCH presents address 0.

Configuration
REQ-033 Macro CALL_STACK_EN defined: SYS src=1 CALL pushes PC+1 and jumps to DataOut_Bus; SYS src=2 RET pops into PC.
REQ-034 CALL when stack full or RET when empty: executes as NOP (PC+1) and sets Err until reset.
REQ-035 CALL_STACK_EN undefined: no stack logic; SYS src=1/2 are NOPs; Err tied 0.

Structure
REQ-036 Package control_pkg holds opcode, state, fun, outbus and condition-code constants.
REQ-037 Sub-module ret_stack (LIFO, STACK_DEPTH x ADDR_W, full/empty flags) instantiated only under CALL_STACK_EN.

Verification
REQ-038 Rst low at t0, release -> Address_Instruction_Bus=0, all outputs idle, Halted=0, Err=0.
REQ-039 ms_m=001_010_001 (MOV r2,r1) -> EXECUTE b_sel=00000010, outbus=01; WRITEBACK LE_sel=1, c_sel=2; next FETCH PC=1.
REQ-040 ADD with band=001 then JMP cond 1 target DataOut_Bus=0x40 -> PC=0x40; repeated with band=000 -> PC+1.
REQ-041 PC at 0xFF executing NOP -> next PC=0x00; Stall high 5 cycles in FETCH -> PC and IR unchanged.
REQ-042 CALL_STACK_EN, STACK_DEPTH=4: 5 CALLs -> 5th is NOP, Err=1; RETs pop in LIFO order; RET on empty -> Err=1.
REQ-043 SYS src=0 -> Halted=1, PC frozen over 10 cycles; Rst pulse mid-EXECUTE -> no LE_sel, PC=0.
